// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared fetch-stage widths, reset PC, bubble encoding and PC stride
package instruction_fetch_stage_pkg;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
    localparam logic [31:0] NOP              = 32'd0;
    localparam logic [31:0] PC_INC           = 32'd4;
endpackage

// File: rtl/if_id_register.sv
// if_id_register: IF/ID pipeline register; flush clears to a bubble, freeze holds
module if_id_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter int N = INSTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         flush,
    input  logic [N-1:0] pc_in,
    input  logic [N-1:0] instr_in,
    output logic [N-1:0] pc_out,
    output logic [N-1:0] instr_out,
    output logic         valid_out
);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pc_out    <= '0;
            instr_out <= N'(NOP);
            valid_out <= 1'b0;
        end else if (!freeze) begin
            pc_out    <= pc_in;
            instr_out <= instr_in;
            valid_out <= 1'b1;
        end
    end
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC, next-PC select and IF/ID register; IF_PERF_COUNTERS_EN adds fetch/flush counters
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int           N        = INSTR_W,
    parameter logic [N-1:0] RESET_PC = N'(RESET_PC_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freeze,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_addr,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    output logic [N-1:0] pc_id,
    output logic [N-1:0] instr_id,
    output logic         valid_id
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  flush_count
`endif
);
    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_target;
    assign w_pc_plus4 = r_pc + N'(PC_INC);
    // low address bits are silently dropped; misaligned targets are not an error
    assign w_target   = branch_addr & ~N'(3);
    assign imem_addr  = r_pc;
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else
            r_pc <= branch_taken ? w_target : freeze ? r_pc : w_pc_plus4;
    end
    if_id_register #(.N(N)) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .freeze   (freeze),
        .flush    (branch_taken),
        .pc_in    (w_pc_plus4),
        .instr_in (imem_instr),
        .pc_out   (pc_id),
        .instr_out(instr_id),
        .valid_out(valid_id)
    );
`ifdef IF_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (!branch_taken && !freeze)
                fetch_count <= fetch_count + 32'd1;
            if (branch_taken)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule
